// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the PC register input, fetches through a req/ack port and
// feeds decode through the IF/ID register, with a one-entry skid buffer for decode back-pressure.
module fetch_unit #(
    parameter int unsigned INST_ADDR_WIDTH = 16,
    parameter int unsigned INST_WIDTH      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [INST_ADDR_WIDTH-1:0] pc_cur_i,
    output logic [INST_ADDR_WIDTH-1:0] pc_next_o,
    output logic                       imem_req_o,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                       imem_ack_i,
    input  logic [INST_WIDTH-1:0]      imem_data_i,
    input  logic                       br_taken_i,
    input  logic [INST_ADDR_WIDTH-1:0] br_target_i,
    input  logic                       id_stall_i,
    output logic                       if_valid_o,
    output logic [INST_WIDTH-1:0]      if_inst_o,
    output logic [INST_ADDR_WIDTH-1:0] if_pc_o
);

    typedef enum logic [0:0] {StFetch, StBlocked} state_e;

    state_e                     state_q, state_d;
    logic                       if_valid_q, if_valid_d;
    logic [INST_WIDTH-1:0]      if_inst_q, if_inst_d;
    logic [INST_ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [INST_WIDTH-1:0]      buf_inst_q, buf_inst_d;
    logic [INST_ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
    logic                       slot_free;

    assign imem_addr_o = pc_cur_i;
    assign if_valid_o  = if_valid_q;
    assign if_inst_o   = if_inst_q;
    assign if_pc_o     = if_pc_q;

    always_comb begin
        state_d    = state_q;
        if_valid_d = if_valid_q;
        if_inst_d  = if_inst_q;
        if_pc_d    = if_pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        pc_next_o  = pc_cur_i;
        slot_free  = !if_valid_q || !id_stall_i;
        imem_req_o = rst_ni && (state_q == StFetch);

        if (!rst_ni) begin
            // Registers are held by the async reset; keep the PC input stable meanwhile.
            pc_next_o = pc_cur_i;
        end else if (br_taken_i) begin
            pc_next_o  = br_target_i;
            if_valid_d = 1'b0;
            buf_inst_d = '0;
            buf_pc_d   = '0;
            state_d    = StFetch;
        end else begin
            unique case (state_q)
                StFetch: begin
                    if (imem_ack_i) begin
                        pc_next_o = pc_cur_i + INST_ADDR_WIDTH'(1);
                        if (slot_free) begin
                            if_valid_d = 1'b1;
                            if_inst_d  = imem_data_i;
                            if_pc_d    = pc_cur_i;
                        end else begin
                            buf_inst_d = imem_data_i;
                            buf_pc_d   = pc_cur_i;
                            state_d    = StBlocked;
                        end
                    end else if (if_valid_q && !id_stall_i) begin
                        if_valid_d = 1'b0;
                    end
                end
                StBlocked: begin
                    if (!id_stall_i) begin
                        if_valid_d = 1'b1;
                        if_inst_d  = buf_inst_q;
                        if_pc_d    = buf_pc_q;
                        state_d    = StFetch;
                    end
                end
                default: state_d = StFetch;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StFetch;
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            if_pc_q    <= '0;
            buf_inst_q <= '0;
            buf_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            if_valid_q <= if_valid_d;
            if_inst_q  <= if_inst_d;
            if_pc_q    <= if_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: the pipeline contents are modelled as a queue of at most two
// fetched words (IF/ID head plus skid entry); the bench also plays the PC register and memory.
module tb_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_cur;
    logic [15:0] pc_next;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic        id_stall;
    logic        if_valid;
    logic [15:0] if_inst;
    logic [15:0] if_pc;

    entry_t      q[$];
    logic [15:0] pc_m;
    int          errors = 0;
    int          checks = 0;

    fetch_unit #(
        .INST_ADDR_WIDTH(16),
        .INST_WIDTH     (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pc_cur_i   (pc_cur),
        .pc_next_o  (pc_next),
        .imem_req_o (imem_req),
        .imem_addr_o(imem_addr),
        .imem_ack_i (imem_ack),
        .imem_data_i(imem_data),
        .br_taken_i (br_taken),
        .br_target_i(br_target),
        .id_stall_i (id_stall),
        .if_valid_o (if_valid),
        .if_inst_o  (if_inst),
        .if_pc_o    (if_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic step(input logic stall, input logic br, input logic [15:0] tgt,
                        input int unsigned ackp);
        logic        req_m;
        logic        ack;
        logic [15:0] exp_next;
        @(negedge clk);
        req_m     = (q.size() < 2);
        ack       = req_m && ($urandom_range(99) < ackp);
        id_stall  = stall;
        br_taken  = br;
        br_target = tgt;
        imem_ack  = ack;
        imem_data = ack ? (pc_m ^ 16'hA5A5) : 16'($urandom);
        #1;
        exp_next = br ? tgt : ((req_m && ack) ? pc_m + 16'd1 : pc_m);
        chk("imem_req", {31'd0, imem_req}, {31'd0, req_m});
        chk("imem_addr", {16'd0, imem_addr}, {16'd0, pc_m});
        chk("pc_next", {16'd0, pc_next}, {16'd0, exp_next});
        chk("if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) begin
            chk("if_pc", {16'd0, if_pc}, {16'd0, q[0].pc});
            chk("if_inst", {16'd0, if_inst}, {16'd0, q[0].inst});
        end
        if (br) begin
            q.delete();
        end else begin
            if (q.size() > 0 && !stall) void'(q.pop_front());
            if (req_m && ack) q.push_back('{pc: pc_m, inst: pc_m ^ 16'hA5A5});
        end
        pc_m = exp_next;
        @(posedge clk);
        #1;
        pc_cur = pc_m;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(negedge clk);
        #2;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_next", {16'd0, pc_next}, {16'd0, pc_m});
        q.delete();
        pc_m   = 16'd0;
        pc_cur = 16'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        pc_cur    = 16'd0;
        pc_m      = 16'd0;
        imem_ack  = 1'b0;
        imem_data = 16'd0;
        br_taken  = 1'b0;
        br_target = 16'd0;
        id_stall  = 1'b0;
        #1;
        chk("reset_if_valid", {31'd0, if_valid}, 32'd0);
        chk("reset_if_inst", {16'd0, if_inst}, 32'd0);
        chk("reset_if_pc", {16'd0, if_pc}, 32'd0);
        chk("reset_imem_req", {31'd0, imem_req}, 32'd0);
        chk("reset_pc_next", {16'd0, pc_next}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero-wait stream from address 0.
        repeat (4) step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_stream_pc", {16'd0, if_pc}, 32'h0003);
        chk("lit_stream_inst", {16'd0, if_inst}, 32'hA5A6);
        chk("lit_stream_addr", {16'd0, imem_addr}, 32'h0004);

        // Branch near the top of the address space, then wrap.
        step(1'b0, 1'b1, 16'hFFFE, 100);
        chk("lit_br_flush", {31'd0, if_valid}, 32'd0);
        repeat (3) step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_wrap_pc", {16'd0, if_pc}, 32'h0000);
        chk("lit_wrap_inst", {16'd0, if_inst}, 32'hA5A5);

        // Stall with an ack lands in the skid buffer; drain in order.
        repeat (3) step(1'b1, 1'b0, 16'd0, 100);
        chk("lit_blocked_req", {31'd0, imem_req}, 32'd0);
        step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_drain_pc", {16'd0, if_pc}, 32'h0001);
        step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_after_drain_pc", {16'd0, if_pc}, 32'h0002);

        // Branch while blocked with ack present discards both entries.
        step(1'b1, 1'b0, 16'd0, 100);
        step(1'b0, 1'b1, 16'h0100, 100);
        chk("lit_br_blocked_valid", {31'd0, if_valid}, 32'd0);
        chk("lit_br_blocked_addr", {16'd0, imem_addr}, 32'h0100);
        step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_br_target_inst", {16'd0, if_inst}, 32'hA4A5);

        // Reset while blocked; the old skid content must never reappear.
        step(1'b1, 1'b0, 16'd0, 100);
        do_reset();
        step(1'b0, 1'b0, 16'd0, 100);
        chk("lit_restart_pc", {16'd0, if_pc}, 32'h0000);
        chk("lit_restart_inst", {16'd0, if_inst}, 32'hA5A5);

        // Wait-state cycle: no ack leaves address and PC unchanged.
        step(1'b0, 1'b0, 16'd0, 0);
        chk("lit_wait_addr", {16'd0, imem_addr}, 32'h0001);

        // Randomized traffic with wait states, stalls, branches and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(99) < 30, $urandom_range(99) < 4, 16'($urandom), 65);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage wrapped around the program counter register. It drives that register's input with the next PC, reads instructions from instruction memory at the current PC through a req/ack handshake, and holds the result in the IF/ID pipeline register for decode. It also owns sequential increment, branch redirect/flush and decode back-pressure, using a one-entry skid buffer.

## Interface
- INST_ADDR_WIDTH, 16, width of PC and instruction address (word addressed)
- INST_WIDTH, 16, instruction word width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_cur  in  INST_ADDR_WIDTH  current PC from program counter register output
- pc_next  out  INST_ADDR_WIDTH  next PC, wired to program counter register input (combinational)
- imem_req  out  1  fetch request, level
- imem_addr  out  INST_ADDR_WIDTH  fetch address, equals pc_cur
- imem_ack  in  1  imem_data valid for imem_addr this cycle
- imem_data  in  INST_WIDTH  instruction word
- br_taken  in  1  redirect from execute, one-cycle pulse
- br_target  in  INST_ADDR_WIDTH  redirect address
- id_stall  in  1  decode cannot accept this cycle
- if_valid  out  1  IF/ID register holds an instruction
- if_inst  out  INST_WIDTH  IF/ID instruction
- if_pc  out  INST_ADDR_WIDTH  address of if_inst

## Operation
- States: FETCH, BLOCKED. Reset state FETCH.
- Consume event: if_valid && !id_stall at a rising edge. Output slot free this cycle: !if_valid || !id_stall.
- imem_req = rst && state==FETCH. imem_addr = pc_cur always.
- Memory is request-per-cycle: ack refers only to the address presented that same cycle. req may drop or address may change without ack.
- FETCH, imem_ack, slot free: load if_inst=imem_data, if_pc=pc_cur, if_valid=1. pc_next=pc_cur+1. Stay FETCH.
- FETCH, imem_ack, slot not free: load buf_inst/buf_pc, pc_next=pc_cur+1, go BLOCKED.
- FETCH, no ack: pc_next=pc_cur. if_valid cleared if consumed, else held.
- BLOCKED: imem_req=0, pc_next=pc_cur. When !id_stall, move buf into IF/ID (if_valid=1) and go FETCH. Otherwise hold.
- br_taken (highest priority, any state): pc_next=br_target. At the edge, if_valid=0 and buf discarded. Any imem_ack in the same cycle is ignored. State becomes FETCH.
- Arithmetic: pc_cur+1 is modulo 2^INST_ADDR_WIDTH, so 0xFFFF -> 0x0000. No overflow flag.
- if_inst/if_pc are held unchanged when if_valid is not reloaded. Their values are don't-care when if_valid=0.

## Timing
- Reset (rst low, asynchronous): if_valid=0, if_inst=0, if_pc=0, buf cleared, state FETCH, imem_req=0. pc_next=pc_cur. The external PC register resets to 0, so the first fetch is at address 0 in the first cycle after release.
- Ack in cycle N: if_valid=1 with that instruction from cycle N+1. pc_cur=old+1 at N+1. New request issued at N+1.
- With a zero-wait memory and no stall, sustained throughput is 1 instruction/cycle.
- Each wait-state cycle (req high, ack low) adds one cycle. The request holds the same address.
- Stall arriving while ack: the instruction goes to buf, and no further requests are made until drained. No instruction is lost or duplicated.
- br_taken in cycle N: pc_cur=br_target at N+1 and fetch of target begins at N+1. The earliest target instruction appears in if_valid at N+2.
- Reset asserted mid-operation (including BLOCKED or during a wait): returns immediately to reset values. Pending ack is discarded.

## Test plan
- Reset/stream: release reset, zero-wait memory returning data=addr^0xA5A5, no stall -> if_pc sequence 0,1,2,3… on consecutive cycles, if_inst matches, imem_addr 0 first cycle after release.
- Wait states: ack delayed 2 cycles on address 5 -> imem_addr held at 5 for 3 cycles, pc_next=5 until ack, if_pc=5 appears cycle after ack, no gap beyond that.
- Stall with skid: id_stall high 3 cycles while if_valid (pc 3) and ack on pc 4 -> buf holds 4, imem_req=0 while BLOCKED. Release -> if_pc 3 consumed, then 4, then 5. Each consumed exactly once.
- Branch flush: br_taken with br_target=0x0100 while if_valid and buf full, and ack present -> next cycle if_valid=0, pc_cur=0x0100, next delivered if_pc=0x0100. No pre-branch instruction appears after flush.
- Wrap-around: br_target=0xFFFE, stream -> if_pc 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Reset mid-stall: assert rst while BLOCKED -> outputs reset asynchronously (if_valid=0, imem_req=0). After release, fetch restarts at 0 and the old buf content never appears.
